// File: rtl/zap_shift_operand_stage_pkg.sv
// Shared definitions for the shift operand stage: internal shift-type codes,
// handshake FSM states and ARM shift-op encodings.
package zap_shift_operand_stage_pkg;

   localparam int SHIFT_OPS_DEF = 10;
   localparam int SHW_DEF       = $clog2(SHIFT_OPS_DEF);

   // Internal shift types understood by the barrel shifter.
   typedef enum logic [SHW_DEF-1:0] {
      LSL  = 4'd0,
      LSR  = 4'd1,
      ASR  = 4'd2,
      ROR  = 4'd3,
      LSLI = 4'd4,
      LSRI = 4'd5,
      ASRI = 4'd6,
      RORI = 4'd7,
      ROTI = 4'd8,
      RRC  = 4'd9
   } shift_type_t;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FULL    = 2'd1,
      ST_WAIT_RS = 2'd2
   } state_t;

   localparam logic [1:0] OP_LSL = 2'd0;
   localparam logic [1:0] OP_LSR = 2'd1;
   localparam logic [1:0] OP_ASR = 2'd2;
   localparam logic [1:0] OP_ROR = 2'd3;

   // ARM encodes LSR/ASR #32 as an immediate of zero.
   function automatic logic [7:0] imm_or_32(input logic [4:0] imm);
      return (imm == 5'd0) ? 8'd32 : {3'b000, imm};
   endfunction

endpackage

// File: rtl/zap_shift_operand_stage_encode.sv
// Combinational translation of ARM shift fields into the shifter's internal
// shift type plus the amount implied by an immediate encoding.
module zap_shift_encode
   import zap_shift_operand_stage_pkg::*;
(
   input  logic [1:0]  i_op,
   input  logic [4:0]  i_imm,
   input  logic        i_reg_shift,
   input  logic        i_rot_imm,
   output shift_type_t o_type,
   output logic [7:0]  o_imm_amount
);

   always_comb begin
      o_type       = LSL;
      o_imm_amount = 8'd0;
      if (i_rot_imm) begin
         o_type       = ROTI;
         o_imm_amount = {3'b000, i_imm[3:0], 1'b0};
      end else if (i_reg_shift) begin
         // Amount is supplied by Rs; only the type is decided here.
         case (i_op)
            OP_LSL:  o_type = LSL;
            OP_LSR:  o_type = LSR;
            OP_ASR:  o_type = ASR;
            default: o_type = ROR;
         endcase
      end else begin
         case (i_op)
            OP_LSL: begin
               o_type       = LSLI;
               o_imm_amount = {3'b000, i_imm};
            end
            OP_LSR: begin
               o_type       = LSRI;
               o_imm_amount = imm_or_32(i_imm);
            end
            OP_ASR: begin
               o_type       = ASRI;
               o_imm_amount = imm_or_32(i_imm);
            end
            default: begin
               if (i_imm == 5'd0) begin
                  o_type       = RRC;
                  o_imm_amount = 8'd0;
               end else begin
                  o_type       = RORI;
                  o_imm_amount = {3'b000, i_imm};
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/zap_shift_operand_stage.sv
// Operand stage ahead of the barrel shifter: encodes shift fields, waits for a
// forwarded Rs when needed, and holds registered operands under backpressure.
module zap_shift_operand_stage
   import zap_shift_operand_stage_pkg::*;
#(
   parameter int SHIFT_OPS = 10,
   parameter int TAG_W     = 4
)
(
   input  logic                         i_clk,
   input  logic                         i_reset_n,
   input  logic                         i_clear,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic [31:0]                  i_source,
   input  logic [1:0]                   i_op,
   input  logic                         i_reg_shift,
   input  logic                         i_rot_imm,
   input  logic [4:0]                   i_imm_amount,
   input  logic [31:0]                  i_rs_value,
   input  logic                         i_rs_pending,
   input  logic [TAG_W-1:0]             i_rs_tag,
   input  logic                         i_carry,
   input  logic                         i_fwd_valid,
   input  logic [TAG_W-1:0]             i_fwd_tag,
   input  logic [31:0]                  i_fwd_data,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [31:0]                  o_source,
   output logic [7:0]                   o_amount,
   output logic [$clog2(SHIFT_OPS)-1:0] o_shift_type,
   output logic                         o_carry
);

   localparam int SHW = $clog2(SHIFT_OPS);

   state_t           r_state;
   logic [31:0]      r_source;
   logic [7:0]       r_amount;
   shift_type_t      r_type;
   logic             r_carry;
   logic [TAG_W-1:0] r_tag;

   state_t           w_state_nxt;
   logic [31:0]      w_source_nxt;
   logic [7:0]       w_amount_nxt;
   shift_type_t      w_type_nxt;
   logic             w_carry_nxt;
   logic [TAG_W-1:0] w_tag_nxt;

   shift_type_t      w_enc_type;
   logic [7:0]       w_enc_amount;
   logic             w_accept;
   logic             w_reg_path;
   logic             w_issue_hit;
   logic             w_wait_hit;

   // Shift amounts are 8 bits; the upper register bits are never consumed.
   logic             w_unused;
   assign w_unused = &{1'b0, i_rs_value[31:8], i_fwd_data[31:8]};

   zap_shift_encode u_encode (
      .i_op         (i_op),
      .i_imm        (i_imm_amount),
      .i_reg_shift  (i_reg_shift),
      .i_rot_imm    (i_rot_imm),
      .o_type       (w_enc_type),
      .o_imm_amount (w_enc_amount)
   );

   assign o_valid      = (r_state == ST_FULL);
   assign o_ready      = (r_state != ST_WAIT_RS) && (!o_valid || i_ready);
   assign w_accept     = i_valid && o_ready;
   assign w_reg_path   = i_reg_shift && !i_rot_imm;
   assign w_issue_hit  = i_fwd_valid && (i_fwd_tag == i_rs_tag);
   assign w_wait_hit   = i_fwd_valid && (i_fwd_tag == r_tag);

   assign o_source     = r_source;
   assign o_amount     = r_amount;
   assign o_shift_type = SHW'(r_type);
   assign o_carry      = r_carry;

   always_comb begin
      w_state_nxt  = r_state;
      w_source_nxt = r_source;
      w_amount_nxt = r_amount;
      w_type_nxt   = r_type;
      w_carry_nxt  = r_carry;
      w_tag_nxt    = r_tag;
      if (i_clear) begin
         w_state_nxt = ST_EMPTY;
      end else if (r_state == ST_WAIT_RS) begin
         if (w_wait_hit) begin
            w_amount_nxt = i_fwd_data[7:0];
            w_state_nxt  = ST_FULL;
         end
      end else if (w_accept) begin
         w_source_nxt = i_source;
         w_type_nxt   = w_enc_type;
         w_carry_nxt  = i_carry;
         w_tag_nxt    = i_rs_tag;
         w_state_nxt  = ST_FULL;
         if (!w_reg_path) begin
            w_amount_nxt = w_enc_amount;
         end else if (!i_rs_pending) begin
            w_amount_nxt = i_rs_value[7:0];
         end else if (w_issue_hit) begin
            w_amount_nxt = i_fwd_data[7:0];
         end else begin
            w_amount_nxt = i_rs_value[7:0];
            w_state_nxt  = ST_WAIT_RS;
         end
      end else if ((r_state == ST_FULL) && i_ready) begin
         w_state_nxt = ST_EMPTY;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state  <= ST_EMPTY;
         r_source <= 32'd0;
         r_amount <= 8'd0;
         r_type   <= LSL;
         r_carry  <= 1'b0;
         r_tag    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_source <= w_source_nxt;
         r_amount <= w_amount_nxt;
         r_type   <= w_type_nxt;
         r_carry  <= w_carry_nxt;
         r_tag    <= w_tag_nxt;
      end
   end

endmodule

// File: tb/tb_zap_shift_operand_stage.sv
// Scoreboard bench for zap_shift_operand_stage: directed vectors push expected
// shifter operands; a monitor pops and compares on every output transfer.
module tb_zap_shift_operand_stage;
   import zap_shift_operand_stage_pkg::*;

   logic        clk;
   logic        i_reset_n;
   logic        i_clear;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_source;
   logic [1:0]  i_op;
   logic        i_reg_shift;
   logic        i_rot_imm;
   logic [4:0]  i_imm_amount;
   logic [31:0] i_rs_value;
   logic        i_rs_pending;
   logic [3:0]  i_rs_tag;
   logic        i_carry;
   logic        i_fwd_valid;
   logic [3:0]  i_fwd_tag;
   logic [31:0] i_fwd_data;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_source;
   logic [7:0]  o_amount;
   logic [3:0]  o_shift_type;
   logic        o_carry;

   typedef struct packed {
      logic [31:0] src;
      logic [7:0]  amt;
      logic [3:0]  typ;
      logic        c;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   zap_shift_operand_stage #(.SHIFT_OPS(10), .TAG_W(4)) dut (
      .i_clk        (clk),
      .i_reset_n    (i_reset_n),
      .i_clear      (i_clear),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_source     (i_source),
      .i_op         (i_op),
      .i_reg_shift  (i_reg_shift),
      .i_rot_imm    (i_rot_imm),
      .i_imm_amount (i_imm_amount),
      .i_rs_value   (i_rs_value),
      .i_rs_pending (i_rs_pending),
      .i_rs_tag     (i_rs_tag),
      .i_carry      (i_carry),
      .i_fwd_valid  (i_fwd_valid),
      .i_fwd_tag    (i_fwd_tag),
      .i_fwd_data   (i_fwd_data),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_source     (o_source),
      .o_amount     (o_amount),
      .o_shift_type (o_shift_type),
      .o_carry      (o_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("check %s: %0h ok", name, act);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] s, input logic [7:0] a,
                               input shift_type_t t, input logic c);
      exp_t e;
      e.src = s;
      e.amt = a;
      e.typ = 4'(t);
      e.c   = c;
      return e;
   endfunction

   // Transfers happen at the posedge following a negedge with o_valid && i_ready.
   always @(negedge clk) begin
      if (i_reset_n && o_valid && i_ready) begin
         exp_t got;
         exp_t exp;
         got = {o_source, o_amount, o_shift_type, o_carry};
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL xfer_unexpected: got src=%0h amt=%0h type=%0d c=%0b required none",
                     o_source, o_amount, o_shift_type, o_carry);
         end else begin
            exp = sb_q.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL xfer: got src=%0h amt=%0h type=%0d c=%0b required src=%0h amt=%0h type=%0d c=%0b",
                        got.src, got.amt, got.typ, got.c, exp.src, exp.amt, exp.typ, exp.c);
            end else begin
               $display("xfer src=%0h amt=%0h type=%0d c=%0b ok", got.src, got.amt, got.typ, got.c);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one operation; returns at posedge+1 after it has been accepted.
   task automatic send(input logic [31:0] src, input logic [1:0] op, input logic reg_s,
                       input logic rot, input logic [4:0] imm, input logic [31:0] rs,
                       input logic pend, input logic [3:0] tag, input logic c);
      bit ok;
      i_source     = src;
      i_op         = op;
      i_reg_shift  = reg_s;
      i_rot_imm    = rot;
      i_imm_amount = imm;
      i_rs_value   = rs;
      i_rs_pending = pend;
      i_rs_tag     = tag;
      i_carry      = c;
      i_valid      = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (o_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got o_ready=0 for 20 cycles required 1");
      end
      step();
      i_valid = 1'b0;
   endtask

   initial begin
      i_reset_n = 1'b0; i_clear = 1'b0; i_valid = 1'b0; i_source = '0; i_op = '0;
      i_reg_shift = 1'b0; i_rot_imm = 1'b0; i_imm_amount = '0; i_rs_value = '0;
      i_rs_pending = 1'b0; i_rs_tag = '0; i_carry = 1'b0; i_fwd_valid = 1'b0;
      i_fwd_tag = '0; i_fwd_data = '0; i_ready = 1'b1;
      repeat (3) step();
      i_reset_n = 1'b1;
      @(negedge clk);
      chk("reset_valid", 64'(o_valid), 64'd0);
      chk("reset_ready", 64'(o_ready), 64'd1);
      chk("reset_outs", {o_source, o_amount, o_carry}, 64'd0);
      chk("reset_type", 64'(o_shift_type), 64'(LSL));
      step();

      // Immediate encodings
      sb_q.push_back(mk(32'h8000_0000, 8'd32, LSRI, 1'b0));
      send(32'h8000_0000, OP_LSR, 0, 0, 5'd0, 32'h0, 0, 4'd0, 1'b0);
      @(negedge clk);
      chk("lsr0_latency", 64'(o_valid), 64'd1);
      step();
      sb_q.push_back(mk(32'h0000_0001, 8'd0, RRC, 1'b1));
      send(32'h0000_0001, OP_ROR, 0, 0, 5'd0, 32'h0, 0, 4'd0, 1'b1);
      sb_q.push_back(mk(32'h1234_5678, 8'd4, RORI, 1'b0));
      send(32'h1234_5678, OP_ROR, 0, 0, 5'd4, 32'h0, 0, 4'd0, 1'b0);
      sb_q.push_back(mk(32'h0000_00FF, 8'd30, ROTI, 1'b0));
      send(32'h0000_00FF, OP_ASR, 1, 1, 5'h0F, 32'h0, 1, 4'd1, 1'b0);
      sb_q.push_back(mk(32'hA5A5_0000, 8'd3, LSLI, 1'b1));
      send(32'hA5A5_0000, OP_LSL, 0, 0, 5'd3, 32'h0, 0, 4'd0, 1'b1);
      sb_q.push_back(mk(32'hF000_000F, 8'd32, ASRI, 1'b0));
      send(32'hF000_000F, OP_ASR, 0, 0, 5'd0, 32'h0, 0, 4'd0, 1'b0);
      sb_q.push_back(mk(32'h0000_0F0F, 8'h21, ASR, 1'b0));
      send(32'h0000_0F0F, OP_ASR, 1, 0, 5'd7, 32'h0000_0121, 0, 4'd0, 1'b0);

      // Register shift waiting on forwarded Rs
      send(32'h0000_0011, OP_LSL, 1, 0, 5'd0, 32'h0, 1, 4'd3, 1'b1);
      i_fwd_valid = 1'b1; i_fwd_tag = 4'd5; i_fwd_data = 32'h0000_0003;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("wait_ready", 64'(o_ready), 64'd0);
         chk("wait_valid", 64'(o_valid), 64'd0);
         step();
      end
      i_fwd_tag = 4'd3; i_fwd_data = 32'h0000_0107;
      sb_q.push_back(mk(32'h0000_0011, 8'h07, LSL, 1'b1));
      step();
      i_fwd_valid = 1'b0;
      @(negedge clk);
      chk("fwd_valid", 64'(o_valid), 64'd1);
      step();

      // Same-cycle forward bypass
      i_fwd_valid = 1'b1; i_fwd_tag = 4'd3; i_fwd_data = 32'h0000_0240;
      sb_q.push_back(mk(32'h0000_0022, 8'h40, LSR, 1'b0));
      send(32'h0000_0022, OP_LSR, 1, 0, 5'd0, 32'h0, 1, 4'd3, 1'b0);
      i_fwd_valid = 1'b0;
      @(negedge clk);
      chk("bypass_valid", 64'(o_valid), 64'd1);
      step();

      // Backpressure then back-to-back transfer
      i_ready = 1'b0;
      sb_q.push_back(mk(32'hCAFE_0001, 8'd1, LSLI, 1'b0));
      send(32'hCAFE_0001, OP_LSL, 0, 0, 5'd1, 32'h0, 0, 4'd0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_valid", 64'(o_valid), 64'd1);
         chk("bp_ready", 64'(o_ready), 64'd0);
         chk("bp_hold", {o_source, o_amount, o_shift_type}, {20'd0, 32'hCAFE_0001, 8'd1, 4'(LSLI)});
         step();
      end
      i_ready = 1'b1;
      sb_q.push_back(mk(32'hCAFE_0002, 8'd2, LSLI, 1'b1));
      send(32'hCAFE_0002, OP_LSL, 0, 0, 5'd2, 32'h0, 0, 4'd0, 1'b1);
      @(negedge clk);
      chk("b2b_valid", 64'(o_valid), 64'd1);
      step();

      // Clear while waiting for Rs
      send(32'h0000_0033, OP_ROR, 1, 0, 5'd0, 32'h0, 1, 4'd2, 1'b0);
      i_clear = 1'b1;
      step();
      i_clear = 1'b0;
      @(negedge clk);
      chk("clr_wait_valid", 64'(o_valid), 64'd0);
      chk("clr_wait_ready", 64'(o_ready), 64'd1);
      step();
      i_fwd_valid = 1'b1; i_fwd_tag = 4'd2; i_fwd_data = 32'h0000_0009;
      step();
      i_fwd_valid = 1'b0;
      @(negedge clk);
      chk("clr_wait_stale_fwd", 64'(o_valid), 64'd0);
      step();

      // Clear while FULL, with a new op offered in the same cycle
      sb_q.push_back(mk(32'h0000_0044, 8'd5, LSLI, 1'b0));
      send(32'h0000_0044, OP_LSL, 0, 0, 5'd5, 32'h0, 0, 4'd0, 1'b0);
      i_clear = 1'b1; i_valid = 1'b1; i_source = 32'h0000_0055; i_op = OP_LSL;
      i_reg_shift = 1'b0; i_rot_imm = 1'b0; i_imm_amount = 5'd6;
      step();
      i_clear = 1'b0; i_valid = 1'b0;
      @(negedge clk);
      chk("clr_full_drop", 64'(o_valid), 64'd0);
      step();
      i_ready = 1'b0;
      send(32'h0000_0066, OP_LSL, 0, 0, 5'd7, 32'h0, 0, 4'd0, 1'b0);
      i_clear = 1'b1;
      step();
      i_clear = 1'b0;
      @(negedge clk);
      chk("clr_full_stalled", 64'(o_valid), 64'd0);
      step();
      i_ready = 1'b1;

      // Asynchronous reset while waiting for Rs
      send(32'hDEAD_BEEF, OP_ASR, 1, 0, 5'd0, 32'h0, 1, 4'd6, 1'b1);
      @(negedge clk);
      chk("wait_src_held", 64'(o_source), 64'hDEAD_BEEF);
      #2;
      i_reset_n = 1'b0;
      #1;
      chk("arst_outs", {o_source, o_amount, o_carry}, 64'd0);
      chk("arst_type", 64'(o_shift_type), 64'(LSL));
      chk("arst_valid", 64'(o_valid), 64'd0);
      step();
      i_reset_n = 1'b1;
      i_fwd_valid = 1'b1; i_fwd_tag = 4'd6; i_fwd_data = 32'h0000_0004;
      step();
      i_fwd_valid = 1'b0;
      @(negedge clk);
      chk("arst_stays_empty", 64'(o_valid), 64'd0);

      repeat (3) step();
      chk("sb_drain", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
